// File: rtl/histogram_eq_param_if.sv
// Pixel-stream bus between the pixel source/writer side and histogram_eq_param.
interface histogram_eq_param_if #(
    parameter int DATA_W = 8
);
    logic              valid_in;
    logic [DATA_W-1:0] point_data_in;
    logic              image_write_done;
    logic              init_done;
    logic              data_read_start;
    logic              valid_out;
    logic [DATA_W-1:0] point_data_out;
    logic              data_read_done;
    logic              drop_err;

    modport master (
        output valid_in, point_data_in, image_write_done,
        input  init_done, data_read_start, valid_out, point_data_out,
               data_read_done, drop_err
    );

    modport slave (
        input  valid_in, point_data_in, image_write_done,
        output init_done, data_read_start, valid_out, point_data_out,
               data_read_done, drop_err
    );
endinterface

// File: rtl/histogram_eq_param.sv
// Two-pass histogram equalizer: accumulate histogram, build CDF remap LUT, remap re-streamed frame.
// Define HIST_EQ_CLIP_EN to clip each bin at CLIP_LIMIT (with a total pre-pass) during CDF.
module histogram_eq_param #(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 20,
    parameter int CLIP_LIMIT = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    histogram_eq_param_if.slave  bus
);
    localparam int DEPTH  = 2 ** DATA_W;
    localparam int NUM_W  = CNT_W + DATA_W;
    localparam int DIV_CW = $clog2(NUM_W);
    localparam logic [DATA_W-1:0] LAST    = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CLIP_V  =
        (CLIP_LIMIT >= 2 ** CNT_W) ? CNT_MAX : CNT_W'(CLIP_LIMIT);
    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(NUM_W - 1);
`ifdef HIST_EQ_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_CLEAR, S_ACCUM, S_ADRAIN, S_CLIPSUM, S_CDF_ACC, S_CDF_DIV, S_MAP, S_MDRAIN
    } state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   addr;
    logic                dcnt;
    logic [DIV_CW-1:0]   div_cnt;
    logic [CNT_W-1:0]    hist [DEPTH];
    logic [DATA_W-1:0]   lut  [DEPTH];
    logic [CNT_W-1:0]    total, cum, cum_n, bin_c;
    logic                vld_p0, vld_p1, map_vld_p0;
    logic [DATA_W-1:0]   pix_p0, pix_p1;
    logic [CNT_W-1:0]    rd_p0, wv_p1, fwd_cnt, wv;
    logic [NUM_W-1:0]    num, q_next;
    logic [NUM_W-2:0]    quo;
    logic [CNT_W-1:0]    rem, rem_next;
    logic [CNT_W:0]      trial;
    logic                qbit;
    logic                hist_we, lut_we;
    logic [DATA_W-1:0]   hist_wa, lut_wd;
    logic [CNT_W-1:0]    hist_wd;
    logic                init_done_r, dstart_r, vout_r, drd_r, drop_r;
    logic [DATA_W-1:0]   pdo_r;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
        return sat_add(a, CNT_W'(1));
    endfunction

    function automatic logic [CNT_W-1:0] clip_bin(input logic [CNT_W-1:0] b);
        return (CLIP_EN && (b > CLIP_V)) ? CLIP_V : b;
    endfunction

    function automatic logic [DATA_W-1:0] sat_lut(input logic [NUM_W-1:0] q);
        return (q > NUM_W'(DEPTH - 1)) ? '1 : q[DATA_W-1:0];
    endfunction

    always_comb begin
        state_n = state;
        case (state)
            S_CLEAR:   if (addr == LAST) state_n = S_ACCUM;
            S_ACCUM:   if (bus.image_write_done) state_n = S_ADRAIN;
            S_ADRAIN:  if (dcnt) state_n = CLIP_EN ? S_CLIPSUM : S_CDF_ACC;
            S_CLIPSUM: if (addr == LAST) state_n = S_CDF_ACC;
            S_CDF_ACC: begin
                if (total != '0)        state_n = S_CDF_DIV;
                else if (addr == LAST)  state_n = S_MAP;
            end
            S_CDF_DIV: if (div_cnt == DIV_LAST) state_n = (addr == LAST) ? S_MAP : S_CDF_ACC;
            S_MAP:     if (bus.image_write_done) state_n = S_MDRAIN;
            S_MDRAIN:  if (dcnt) state_n = S_CLEAR;
            default:   state_n = S_CLEAR;
        endcase
    end

    // Forwarding: a write issued last cycle to the same bin is newer than the RAM read.
    always_comb begin
        fwd_cnt  = (vld_p1 && (pix_p1 == pix_p0)) ? wv_p1 : rd_p0;
        wv       = sat_inc(fwd_cnt);
        bin_c    = clip_bin(hist[addr]);
        cum_n    = sat_add(cum, bin_c);
        trial    = {rem, num[NUM_W-1]};
        qbit     = (trial >= {1'b0, total});
        rem_next = qbit ? CNT_W'(trial - {1'b0, total}) : trial[CNT_W-1:0];
        q_next   = {quo, qbit};
        hist_we  = (state == S_CLEAR) || vld_p0;
        hist_wa  = (state == S_CLEAR) ? addr : pix_p0;
        hist_wd  = (state == S_CLEAR) ? '0 : wv;
        lut_we   = ((state == S_CDF_ACC) && (total == '0)) ||
                   ((state == S_CDF_DIV) && (div_cnt == DIV_LAST));
        lut_wd   = (state == S_CDF_ACC) ? addr : sat_lut(q_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_CLEAR;
            addr        <= '0;
            dcnt        <= 1'b0;
            div_cnt     <= '0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            map_vld_p0  <= 1'b0;
            init_done_r <= 1'b0;
            dstart_r    <= 1'b0;
            vout_r      <= 1'b0;
            pdo_r       <= '0;
            drd_r       <= 1'b0;
            drop_r      <= 1'b0;
        end else begin
            state       <= state_n;
            vld_p0      <= bus.valid_in && (state == S_ACCUM);
            vld_p1      <= vld_p0;
            map_vld_p0  <= bus.valid_in && (state == S_MAP);
            dcnt        <= (state == S_ADRAIN || state == S_MDRAIN) ? ~dcnt : 1'b0;
            div_cnt     <= (state == S_CDF_DIV) ? div_cnt + 1'b1 : '0;
            case (state)
                S_CLEAR, S_CLIPSUM: addr <= addr + 1'b1;
                S_CDF_ACC: if (total == '0) addr <= addr + 1'b1;
                S_CDF_DIV: if (div_cnt == DIV_LAST) addr <= addr + 1'b1;
                default:   addr <= '0;
            endcase
            init_done_r <= (state == S_ACCUM) && !bus.image_write_done;
            dstart_r    <= (state_n == S_MAP) || (state_n == S_MDRAIN);
            drd_r       <= (state == S_MDRAIN) && dcnt;
            vout_r      <= map_vld_p0;
            if (map_vld_p0) pdo_r <= lut[pix_p0];
            if (bus.valid_in && (state inside {S_CLEAR, S_CLIPSUM, S_CDF_ACC, S_CDF_DIV}))
                drop_r <= 1'b1;
        end
    end

    // Stage p0 captures pixel and bin read; stage p1 holds the last write for forwarding.
    always_ff @(posedge clk) begin
        pix_p0 <= bus.point_data_in;
        rd_p0  <= hist[bus.point_data_in];
        pix_p1 <= pix_p0;
        wv_p1  <= wv;
        if (hist_we) hist[hist_wa] <= hist_wd;
        if (lut_we)  lut[addr]     <= lut_wd;
        case (state)
            S_CLEAR:   total <= '0;
            S_ADRAIN: begin
                cum <= '0;
                if (dcnt && CLIP_EN) total <= '0;
            end
            S_CLIPSUM: total <= sat_add(total, bin_c);
            S_CDF_ACC: begin
                cum <= cum_n;
                num <= {cum_n, DATA_W'(0)} - NUM_W'(cum_n);
                rem <= '0;
                quo <= '0;
            end
            S_CDF_DIV: begin
                rem <= rem_next;
                num <= num << 1;
                quo <= q_next[NUM_W-2:0];
            end
            default: ;
        endcase
        if (vld_p0) total <= sat_inc(total);
    end

    assign bus.init_done       = init_done_r;
    assign bus.data_read_start = dstart_r;
    assign bus.valid_out       = vout_r;
    assign bus.point_data_out  = pdo_r;
    assign bus.data_read_done  = drd_r;
    assign bus.drop_err        = drop_r;
endmodule

// File: tb/tb_histogram_eq_param.sv
// Bench for histogram_eq_param: main instance (CNT_W=20, CLIP_LIMIT=4) and a CNT_W=4 saturation instance.
module tb_histogram_eq_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel;
    logic       vin;
    logic [7:0] pin;
    logic       iwd;

    histogram_eq_param_if #(.DATA_W(8)) if_m ();
    histogram_eq_param_if #(.DATA_W(8)) if_s ();

    assign if_m.valid_in         = vin & ~sel;
    assign if_m.point_data_in    = pin;
    assign if_m.image_write_done = iwd & ~sel;
    assign if_s.valid_in         = vin & sel;
    assign if_s.point_data_in    = pin;
    assign if_s.image_write_done = iwd & sel;

    histogram_eq_param #(.DATA_W(8), .CNT_W(20), .CLIP_LIMIT(4)) u_main (
        .clk(clk), .rst_n(rst_n), .bus(if_m.slave));
    histogram_eq_param #(.DATA_W(8), .CNT_W(4), .CLIP_LIMIT(4096)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(if_s.slave));

    logic       o_init, o_dstart, o_vout, o_drd, o_drop;
    logic [7:0] o_pdo;
    assign o_init   = sel ? if_s.init_done       : if_m.init_done;
    assign o_dstart = sel ? if_s.data_read_start : if_m.data_read_start;
    assign o_vout   = sel ? if_s.valid_out       : if_m.valid_out;
    assign o_pdo    = sel ? if_s.point_data_out  : if_m.point_data_out;
    assign o_drd    = sel ? if_s.data_read_done  : if_m.data_read_done;
    assign o_drop   = sel ? if_s.drop_err        : if_m.drop_err;

`ifdef HIST_EQ_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_lut [256];
    int hold [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count pixels, saturate/clip bins, prefix-sum CDF, scale by 255/total.
    task automatic model(input int px[$]);
        longint cnt [256];
        longint hc [256];
        longint maxc, lim, sumh, tot, cum;
        maxc = (longint'(1) << (sel ? 4 : 20)) - 1;
        lim  = sel ? 4096 : 4;
        foreach (cnt[v]) cnt[v] = 0;
        foreach (px[i]) cnt[px[i]] += 1;
        sumh = 0;
        foreach (hc[v]) begin
            hc[v] = (cnt[v] > maxc) ? maxc : cnt[v];
            if (CLIP_EN && hc[v] > lim) hc[v] = lim;
            sumh += hc[v];
        end
        tot = CLIP_EN ? sumh : longint'(px.size());
        if (tot > maxc) tot = maxc;
        cum = 0;
        foreach (hc[v]) begin
            cum += hc[v];
            if (cum > maxc) cum = maxc;
            exp_lut[v] = (tot == 0) ? v : int'(cum * 255 / tot);
        end
    endtask

    task automatic wait_init(input string tag);
        int k;
        k = 0;
        while (o_init !== 1'b1 && k < 3000) begin
            tick();
            k++;
        end
        chk({tag, "_init_done"}, 32'(o_init), 1);
    endtask

    task automatic pass1(input int px[$], input bit gaps);
        if (px.size() == 0) begin
            vin = 1'b0;
            iwd = 1'b1;
            tick();
        end else begin
            for (int i = 0; i < px.size(); i++) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    vin = 1'b0;
                    iwd = 1'b0;
                    tick();
                end
                vin = 1'b1;
                pin = 8'(px[i]);
                iwd = (i == px.size() - 1);
                tick();
            end
        end
        vin = 1'b0;
        iwd = 1'b0;
        chk("init_done_drop_on_marker", 32'(o_init), 0);
    endtask

    task automatic wait_map();
        int k;
        k = 0;
        while (o_dstart !== 1'b1 && k < 20000) begin
            tick();
            k++;
        end
        chk("data_read_start", 32'(o_dstart), 1);
        chk("drop_err_clean", 32'(o_drop), 0);
    endtask

    task automatic check_out(input bit pv, input int pe, inout int nout);
        chk("valid_out", 32'(o_vout), 32'(pv));
        if (pv) begin
            hold[sel] = pe;
            nout++;
        end
        chk("point_data_out", 32'(o_pdo), 32'(hold[sel]));
    endtask

    task automatic pass2(input int px[$], input bit gaps);
        int  cyc[$];
        bit  pv;
        int  pe;
        int  nout;
        pv = 1'b0;
        pe = 0;
        nout = 0;
        foreach (px[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) cyc.push_back(-1);
            cyc.push_back(px[i]);
        end
        for (int c = 0; c < cyc.size(); c++) begin
            vin = (cyc[c] >= 0);
            pin = (cyc[c] >= 0) ? 8'(cyc[c]) : 8'($urandom_range(0, 255));
            iwd = (c == cyc.size() - 1);
            tick();
            check_out(pv, pe, nout);
            pv = vin;
            pe = vin ? exp_lut[pin] : 0;
        end
        vin = 1'b0;
        iwd = 1'b0;
        tick();
        check_out(pv, pe, nout);
        chk("drd_not_early", 32'(o_drd), 0);
        chk("dstart_in_drain", 32'(o_dstart), 1);
        tick();
        chk("data_read_done", 32'(o_drd), 1);
        chk("dstart_drop", 32'(o_dstart), 0);
        chk("valid_out_idle", 32'(o_vout), 0);
        tick();
        chk("drd_single_pulse", 32'(o_drd), 0);
        chk("valid_out_count", 32'(nout), 32'(px.size()));
    endtask

    task automatic reset_and_time(input string tag);
        int k;
        rst_n = 1'b0;
        vin = 1'b0;
        iwd = 1'b0;
        tick();
        chk({tag, "_init_done"}, 32'(o_init), 0);
        chk({tag, "_dstart"}, 32'(o_dstart), 0);
        chk({tag, "_valid_out"}, 32'(o_vout), 0);
        chk({tag, "_pdo"}, 32'(o_pdo), 0);
        chk({tag, "_drd"}, 32'(o_drd), 0);
        chk({tag, "_drop_err"}, 32'(o_drop), 0);
        hold[0] = 0;
        hold[1] = 0;
        rst_n = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (o_init !== 1'b1 && k < 400);
        chk({tag, "_init_latency"}, 32'(k), 257);
    endtask

    initial begin
        int q[$];
        int m[$];
        rst_n = 1'b0;
        sel = 1'b0;
        vin = 1'b0;
        pin = 8'd0;
        iwd = 1'b0;
        tick();
        reset_and_time("por");

        // Ramp 0..15
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(i);
        model(q);
        pass1(q, 1'b0);
        wait_map();
        pass2(q, 1'b0);

        // Back-to-back identical pixels
        wait_init("const");
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(100);
        model(q);
        pass1(q, 1'b0);
        wait_map();
        pass2('{100, 50, 100, 0, 255, 100, 101}, 1'b1);

        // Empty frame gives identity map
        wait_init("empty");
        q = {};
        model(q);
        pass1(q, 1'b0);
        wait_map();
        pass2('{37, 255, 0, 128}, 1'b0);

        // Clip case: 12 x 10 and 4 x 20
        wait_init("clip");
        q = {};
        for (int i = 0; i < 16; i++) q.push_back((i % 4 == 3) ? 20 : 10);
        model(q);
        pass1(q, 1'b0);
        wait_map();
        pass2('{10, 20, 15, 9, 21}, 1'b0);

        // Random frames with heavy bin collisions and idle gaps
        for (int f = 0; f < 2; f++) begin
            wait_init("rand");
            q = {};
            m = {};
            for (int i = 0; i < 120; i++) q.push_back(int'($urandom_range(0, 23)));
            for (int i = 0; i < 30; i++) m.push_back(int'($urandom_range(0, 31)));
            model(q);
            pass1(q, 1'b1);
            wait_map();
            pass2(m, 1'b1);
        end

        // Saturation on the CNT_W=4 instance
        sel = 1'b1;
        wait_init("sat");
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(7);
        model(q);
        pass1(q, 1'b0);
        wait_map();
        pass2('{7, 6, 8, 7}, 1'b0);
        sel = 1'b0;

        // Drop during CDF, then reset mid-CDF
        wait_init("drop");
        pass1('{5, 6, 7}, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("drop_before", 32'(o_drop), 0);
        vin = 1'b1;
        pin = 8'd3;
        tick();
        vin = 1'b0;
        chk("drop_set", 32'(o_drop), 1);
        tick();
        chk("drop_sticky", 32'(o_drop), 1);
        reset_and_time("midcdf");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/histogram_eq_param.md
Name: histogram_eq_param

Overview:
Parametrised two-pass histogram equalizer for grey-scale pixel streams of width DATA_W.
- Pass 1 (accumulate): builds a 2^DATA_W-bin histogram.
- Then builds a CDF-based remap LUT internally.
- Pass 2 (map): the source re-streams the same frame and the block outputs remapped pixels.
- Sits between the BMP/pixel source and the image writer. Successor to the fixed 8-bit equalizer, adding width/size generality, saturation, drop flagging, and optional clip limiting.

Parameters:
DATA_W, 8, pixel width; histogram/LUT depth = 2^DATA_W
CNT_W, 20, bin/total counter width; max counted pixels = 2^CNT_W-1
CLIP_LIMIT, 4096, per-bin clip ceiling (used only with HIST_EQ_CLIP_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
valid_in  in  1  point_data_in valid this cycle
point_data_in  in  DATA_W  input pixel
image_write_done  in  1  one-cycle end-of-frame marker, used in ACCUM and MAP
init_done  out  1  high while in ACCUM (histogram cleared, accepting pass 1)
data_read_start  out  1  high while in MAP (LUT ready, accepting pass 2)
valid_out  out  1  point_data_out valid
point_data_out  out  DATA_W  remapped pixel
data_read_done  out  1  one-cycle pulse after pass 2 is fully drained
drop_err  out  1  sticky; set when valid_in arrives in CLEAR or CDF

Behaviour:
- Reset (rst_n=0 at clk edge): state CLEAR, bin address 0, all outputs 0, drop_err cleared. Asserting reset in any state, including mid-CDF, aborts the frame. The clear restarts after release.
- CLEAR: writes 0 to hist[addr], addr 0..2^DATA_W-1, one bin per cycle, and clears total. Goes to ACCUM after the last bin. init_done rises the cycle after the last write.
- ACCUM: each valid_in does a read-modify-write of hist[pix].
  - 2-stage pipeline (read, add/write) with forwarding, so back-to-back identical pixels count exactly.
  - Bins and total saturate at 2^CNT_W-1; no wrap.
  - image_write_done: the pixel in the same cycle, if valid, is counted. The pipeline drains for 2 cycles, then goes to CDF. init_done drops on the marker cycle.
- CDF: for v = 0..2^DATA_W-1:
  - cum += hist[v], width CNT_W, saturating.
  - lut[v] = floor(cum*(2^DATA_W-1)/total) via serial restoring divider, CNT_W+DATA_W cycles per bin.
  - If total==0: lut[v]=v (identity).
  - valid_in in this state is dropped and drop_err is set.
  - After the last bin: go to MAP, data_read_start=1.
- MAP: valid_in with pix gives valid_out=1 and point_data_out=lut[pix] exactly 2 cycles later, full throughput.
  - image_write_done (same-cycle pixel included) stops acceptance. After the 2-cycle drain, data_read_done pulses once and data_read_start drops the same cycle. State returns to CLEAR for the next frame.
- Invalid/idle cycles: valid_out=0; point_data_out holds its last value.
- image_write_done in CLEAR/CDF: ignored.

Optional Feature:
HIST_EQ_CLIP_EN
- Defined: each bin's contribution is min(hist[v], CLIP_LIMIT), applied during CDF. total = sum of clipped bins, computed in an extra 2^DATA_W-cycle pre-pass at the start of CDF. Excess is discarded, not redistributed.
- Undefined: no clipping, no pre-pass; total is the ACCUM pixel count. CLIP_LIMIT is unused.

Test Plan:
- Ramp: DATA_W=8, 16 pixels of values 0..15 once each, then image_write_done; re-stream -> out 0 maps to 15, 7 maps to 127, 15 maps to 255; 16 valid_out pulses at 2-cycle latency, then one data_read_done pulse.
- Constant back-to-back: 16 consecutive pixels of 100 -> hist[100]=16 (forwarding); pass 2 input 100 gives 255. LUT probe after a frame with value 50: 50 gives 0.
- Empty frame: image_write_done with no valid pixels -> identity LUT; pass 2 input 37 gives 37, input 255 gives 255.
- Saturation: CNT_W=4, 20 pixels of 7 -> hist and total saturate at 15; pass 2 input 7 gives 255; no wrap to 4.
- Clip (HIST_EQ_CLIP_EN, CLIP_LIMIT=4): 12 pixels of 10 and 4 pixels of 20 -> 10 gives 127, 20 gives 255. Without the macro -> 10 gives 191.
- Reset mid-CDF plus drop: pulse valid_in during CDF -> drop_err=1. Assert rst_n=0 for 1 cycle -> all outputs 0, drop_err=0. init_done re-asserts exactly 2^DATA_W+1 cycles after release.
